// File: rtl/ysyx_040066_axi_arbiter_pkg.sv
// Shared cache/AXI package: bus width defaults, arbiter state and owner
// encodings, and the arbitration pick result.
package ysyx_040066_axi_arbiter_pkg;

  localparam int LINE_LEN_DEF = 512;
  localparam int ADDR_LEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } arb_state_e;

  // OWN_I encodes as 0 so the owner register resets to zero.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;    // some request is pending
    logic   is_wr;  // winner is the D-cache writeback
    owner_e own;    // winning cache
  } pick_t;

endpackage

// File: rtl/ysyx_040066_rr_pick2.sv
// Arbitration decision for the cache-to-bridge arbiter.
//   i_wr_req : D-cache writeback request (absolute priority)
//   i_req_i  : I-cache refill request
//   i_req_d  : D-cache refill request
//   i_last   : last granted reader; the other one wins a read tie
//   o_pick   : winner (valid, write/read, owner)
module ysyx_040066_rr_pick2
  import ysyx_040066_axi_arbiter_pkg::*;
(
  input  logic   i_wr_req,
  input  logic   i_req_i,
  input  logic   i_req_d,
  input  owner_e i_last,
  output pick_t  o_pick
);

  always_comb begin
    o_pick = '{vld: 1'b0, is_wr: 1'b0, own: OWN_I};
    if (i_wr_req) begin
      // Dirty line must leave before any refill can overwrite it.
      o_pick = '{vld: 1'b1, is_wr: 1'b1, own: OWN_D};
    end else if (i_req_i && i_req_d) begin
      o_pick = '{vld: 1'b1, is_wr: 1'b0, own: (i_last == OWN_I) ? OWN_D : OWN_I};
    end else if (i_req_i) begin
      o_pick = '{vld: 1'b1, is_wr: 1'b0, own: OWN_I};
    end else if (i_req_d) begin
      o_pick = '{vld: 1'b1, is_wr: 1'b0, own: OWN_D};
    end
  end

endmodule

// File: rtl/ysyx_040066_axi_arbiter.sv
// Arbiter between I-cache refills, D-cache refills and D-cache writebacks
// onto a single AXI bridge; one downstream transaction at a time.
//   clk, rst          : clock, asynchronous active-low reset
//   i_*               : I-cache refill channel (req/addr in, ready/error/data out)
//   d_rd_*            : D-cache refill channel
//   d_wr_*            : D-cache writeback channel
//   addr, rd_*, wr_*  : bridge side; addr/wr_data are registered copies
// Ready/error/data toward the caches are routed combinationally from the
// bridge in the completing cycle, gated by the current owner.
module ysyx_040066_axi_arbiter
  import ysyx_040066_axi_arbiter_pkg::*;
#(
  parameter int LINE_LEN = LINE_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  // I-cache
  input  logic                i_rd_req,
  input  logic [ADDR_LEN-1:0] i_addr,
  output logic                i_rd_ready,
  output logic                i_rd_error,
  output logic [LINE_LEN-1:0] i_rd_data,
  // D-cache read
  input  logic                d_rd_req,
  input  logic [ADDR_LEN-1:0] d_rd_addr,
  output logic                d_rd_ready,
  output logic                d_rd_error,
  output logic [LINE_LEN-1:0] d_rd_data,
  // D-cache write
  input  logic                d_wr_req,
  input  logic [ADDR_LEN-1:0] d_wr_addr,
  input  logic [LINE_LEN-1:0] d_wr_data,
  output logic                d_wr_ready,
  output logic                d_wr_error,
  // AXI bridge
  output logic [ADDR_LEN-1:0] addr,
  output logic                rd_req,
  input  logic                rd_ready,
  input  logic                rd_error,
  input  logic [LINE_LEN-1:0] rd_data,
  output logic                wr_req,
  output logic [LINE_LEN-1:0] wr_data,
  input  logic                wr_ready,
  input  logic                wr_error
);

  arb_state_e          r_state, w_next;
  owner_e              r_owner;
  owner_e              r_last;
  logic [ADDR_LEN-1:0] r_addr;
  logic [LINE_LEN-1:0] r_wr_data;
  pick_t               w_pick;
  logic                w_grant;
  logic                w_hit_i, w_hit_d, w_hit_w;

  ysyx_040066_rr_pick2 u_pick (
    .i_wr_req (d_wr_req),
    .i_req_i  (i_rd_req),
    .i_req_d  (d_rd_req),
    .i_last   (r_last),
    .o_pick   (w_pick)
  );

  assign w_grant = (r_state == ST_IDLE) && w_pick.vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pick.vld) w_next = w_pick.is_wr ? ST_WR : ST_RD;
      ST_RD:   if (rd_ready)   w_next = ST_IDLE;
      ST_WR:   if (wr_ready)   w_next = ST_IDLE;
      default:                 w_next = ST_IDLE;
    endcase
  end

  // Operands are captured at grant so requesters may drop req mid-flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner   <= OWN_I;
      r_last    <= OWN_I;  // last = I means D wins the first tie
      r_addr    <= '0;
      r_wr_data <= '0;
    end else if (w_grant) begin
      r_owner <= w_pick.own;
      if (w_pick.is_wr) begin
        r_addr    <= d_wr_addr;
        r_wr_data <= d_wr_data;
      end else begin
        r_addr <= (w_pick.own == OWN_I) ? i_addr : d_rd_addr;
        r_last <= w_pick.own;  // pointer moves on read grants only
      end
    end
  end

  assign rd_req  = (r_state == ST_RD);
  assign wr_req  = (r_state == ST_WR);
  assign addr    = r_addr;
  assign wr_data = r_wr_data;

  // Readies outside the matching state are dropped here.
  assign w_hit_i = rd_req && rd_ready && (r_owner == OWN_I);
  assign w_hit_d = rd_req && rd_ready && (r_owner == OWN_D);
  assign w_hit_w = wr_req && wr_ready;

  assign i_rd_ready = w_hit_i;
  assign i_rd_error = w_hit_i && rd_error;
  assign i_rd_data  = w_hit_i ? rd_data : '0;
  assign d_rd_ready = w_hit_d;
  assign d_rd_error = w_hit_d && rd_error;
  assign d_rd_data  = w_hit_d ? rd_data : '0;
  assign d_wr_ready = w_hit_w;
  assign d_wr_error = w_hit_w && wr_error;

endmodule

// File: tb/tb_ysyx_040066_axi_arbiter.sv
module tb_ysyx_040066_axi_arbiter;
  localparam int LL = 512;
  localparam int AL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_rd_req;
  logic [AL-1:0] i_addr;
  logic          i_rd_ready, i_rd_error;
  logic [LL-1:0] i_rd_data;
  logic          d_rd_req;
  logic [AL-1:0] d_rd_addr;
  logic          d_rd_ready, d_rd_error;
  logic [LL-1:0] d_rd_data;
  logic          d_wr_req;
  logic [AL-1:0] d_wr_addr;
  logic [LL-1:0] d_wr_data;
  logic          d_wr_ready, d_wr_error;
  logic [AL-1:0] addr;
  logic          rd_req, rd_ready, rd_error;
  logic [LL-1:0] rd_data;
  logic          wr_req;
  logic [LL-1:0] wr_data;
  logic          wr_ready, wr_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_040066_axi_arbiter #(.LINE_LEN(LL), .ADDR_LEN(AL)) dut (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_addr(i_addr), .i_rd_ready(i_rd_ready),
    .i_rd_error(i_rd_error), .i_rd_data(i_rd_data),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_ready(d_rd_ready),
    .d_rd_error(d_rd_error), .d_rd_data(d_rd_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ready(d_wr_ready), .d_wr_error(d_wr_error),
    .addr(addr), .rd_req(rd_req), .rd_ready(rd_ready), .rd_error(rd_error),
    .rd_data(rd_data), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_error(wr_error)
  );

  // {i_rd_ready, i_rd_error, d_rd_ready, d_rd_error, d_wr_ready, d_wr_error}
  wire [5:0] up = {i_rd_ready, i_rd_error, d_rd_ready, d_rd_error, d_wr_ready, d_wr_error};

  function automatic logic [LL-1:0] rnd_line();
    logic [LL-1:0] r;
    for (int i = 0; i < LL / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle_inputs();
    i_rd_req = 0; i_addr = '0; d_rd_req = 0; d_rd_addr = '0;
    d_wr_req = 0; d_wr_addr = '0; d_wr_data = '0;
    rd_ready = 0; rd_error = 0; rd_data = '0; wr_ready = 0; wr_error = 0;
  endtask

  task automatic do_reset();
    rst = 0; idle_inputs(); cyc(2); rst = 1; cyc(1);
  endtask

  task automatic test_reset();
    rst = 0; idle_inputs();
    i_rd_req = 1; d_wr_req = 1; rd_ready = 1; wr_ready = 1;
    rd_data = rnd_line(); d_wr_data = rnd_line(); i_addr = 32'h1234_5678;
    #1;
    checks++;
    if ({rd_req, wr_req, up} !== 8'h00) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {rd_req, wr_req, up});
    end
    cyc(2);
    checks++;
    if ({addr, wr_data, i_rd_data, d_rd_data} !== '0) begin
      failures++; $display("FAIL reset_data addr=%h wr_data_nz=%0b", addr, |wr_data);
    end
    checks++;
    if ({rd_req, wr_req, up} !== 8'h00) begin
      failures++; $display("FAIL reset_hold got=%b exp=0", {rd_req, wr_req, up});
    end
    idle_inputs(); rst = 1; cyc(1);
    checks++;
    if ({rd_req, wr_req} !== 2'b00) begin
      failures++; $display("FAIL reset_release got=%b exp=00", {rd_req, wr_req});
    end
  endtask

  task automatic test_single_refill();
    logic [LL-1:0] pat;
    int hi = 0;
    pat = rnd_line();
    i_rd_req = 1; i_addr = 32'h8000_0040;
    cyc(1);
    checks++;
    if ({rd_req, wr_req, addr} !== {2'b10, 32'h8000_0040}) begin
      failures++; $display("FAIL refill_start rd=%0b wr=%0b addr=%h exp 1 0 80000040", rd_req, wr_req, addr);
    end
    for (int k = 0; k < 4; k++) begin
      if (rd_req) hi++;
      checks++;
      if (up !== 6'b0) begin failures++; $display("FAIL refill_early_ready got=%b exp=0", up); end
      cyc(1);
    end
    if (rd_req) hi++;
    rd_ready = 1; rd_data = pat; #1;
    checks++;
    if (up !== 6'b100000) begin failures++; $display("FAIL refill_ready got=%b exp=100000", up); end
    checks++;
    if (i_rd_data !== pat || d_rd_data !== '0) begin
      failures++; $display("FAIL refill_data got=%h exp=%h", i_rd_data, pat);
    end
    checks++;
    if (hi !== 5) begin failures++; $display("FAIL refill_rd_req_len got=%0d exp=5", hi); end
    cyc(1);
    i_rd_req = 0; rd_ready = 0; rd_data = '0; #1;
    checks++;
    if (rd_req !== 1'b0) begin failures++; $display("FAIL refill_idle rd_req=%0b exp=0", rd_req); end
    cyc(1);
  endtask

  task automatic test_contention();
    bit fav_d;
    bit exp_d;
    logic [LL-1:0] dat;
    string seq, exp_seq;
    do_reset();
    fav_d = 1; seq = ""; exp_seq = "";
    i_rd_req = 1; i_addr = 32'h8000_2000; d_rd_req = 1; d_rd_addr = 32'h8000_3000;
    for (int g = 0; g < 4; g++) begin
      exp_d = fav_d;
      exp_seq = {exp_seq, exp_d ? "D" : "I"};
      cyc(1);
      checks++;
      if ({rd_req, addr} !== {1'b1, exp_d ? 32'h8000_3000 : 32'h8000_2000}) begin
        failures++; $display("FAIL contention_grant%0d rd=%0b addr=%h exp_owner=%s", g, rd_req, addr, exp_d ? "D" : "I");
      end
      cyc(1);
      dat = rnd_line(); rd_ready = 1; rd_data = dat; #1;
      if (i_rd_ready) seq = {seq, "I"};
      else if (d_rd_ready) seq = {seq, "D"};
      else seq = {seq, "-"};
      checks++;
      if (up !== (exp_d ? 6'b001000 : 6'b100000) || (exp_d ? d_rd_data : i_rd_data) !== dat) begin
        failures++; $display("FAIL contention_ready%0d got=%b owner_d=%0b", g, up, exp_d);
      end
      fav_d = !exp_d;
      cyc(1);
      rd_ready = 0;
      checks++;
      if (rd_req !== 1'b0) begin failures++; $display("FAIL contention_idle%0d rd_req=%0b exp=0", g, rd_req); end
    end
    i_rd_req = 0; d_rd_req = 0;
    checks++;
    if (seq != exp_seq) begin failures++; $display("FAIL contention_order got=%s exp=%s", seq, exp_seq); end
    cyc(1);
  endtask

  task automatic test_wb_priority();
    logic [LL-1:0] pat, dat;
    pat = {(LL/8){8'hA5}};
    d_wr_req = 1; d_wr_addr = 32'h8000_1000; d_wr_data = pat;
    i_rd_req = 1; i_addr = 32'h8000_0080;
    cyc(1);
    checks++;
    if ({rd_req, wr_req, addr} !== {2'b01, 32'h8000_1000} || wr_data !== pat) begin
      failures++; $display("FAIL wb_first rd=%0b wr=%0b addr=%h exp 0 1 80001000", rd_req, wr_req, addr);
    end
    cyc(2);
    wr_ready = 1; #1;
    checks++;
    if (up !== 6'b000010) begin failures++; $display("FAIL wb_ready got=%b exp=000010", up); end
    cyc(1);
    d_wr_req = 0; wr_ready = 0; #1;
    checks++;
    if ({rd_req, wr_req} !== 2'b00) begin failures++; $display("FAIL wb_idle got=%b exp=00", {rd_req, wr_req}); end
    cyc(1);
    checks++;
    if ({rd_req, wr_req, addr} !== {2'b10, 32'h8000_0080}) begin
      failures++; $display("FAIL wb_then_rd rd=%0b wr=%0b addr=%h exp 1 0 80000080", rd_req, wr_req, addr);
    end
    dat = rnd_line(); rd_ready = 1; rd_data = dat; #1;
    checks++;
    if (up !== 6'b100000 || i_rd_data !== dat) begin failures++; $display("FAIL wb_rd_ready got=%b exp=100000", up); end
    cyc(1);
    i_rd_req = 0; rd_ready = 0;
    cyc(1);
  endtask

  task automatic test_error();
    d_rd_req = 1; d_rd_addr = 32'h8000_4440;
    cyc(2);
    rd_ready = 1; rd_error = 1; #1;
    checks++;
    if (up !== 6'b001100) begin failures++; $display("FAIL err_rd got=%b exp=001100", up); end
    cyc(1);
    d_rd_req = 0; rd_ready = 0; rd_error = 0; #1;
    checks++;
    if (rd_req !== 1'b0) begin failures++; $display("FAIL err_idle rd_req=%0b exp=0", rd_req); end
    d_wr_req = 1; d_wr_addr = 32'h8000_5000; d_wr_data = rnd_line();
    cyc(1);
    checks++;
    if ({wr_req, addr} !== {1'b1, 32'h8000_5000}) begin
      failures++; $display("FAIL err_next_req wr=%0b addr=%h exp 1 80005000", wr_req, addr);
    end
    wr_ready = 1; wr_error = 1; #1;
    checks++;
    if (up !== 6'b000011) begin failures++; $display("FAIL err_wr got=%b exp=000011", up); end
    cyc(1);
    d_wr_req = 0; wr_ready = 0; wr_error = 0;
    cyc(1);
  endtask

  task automatic test_reset_mid_rd();
    i_rd_req = 1; i_addr = 32'h8000_6000;
    cyc(1);
    cyc(2);
    #2 rst = 0; rd_ready = 1; #1;
    checks++;
    if ({rd_req, wr_req, up} !== 8'h00) begin
      failures++; $display("FAIL rst_mid_drop got=%b exp=0", {rd_req, wr_req, up});
    end
    cyc(1);
    rst = 1; i_rd_req = 0; rd_ready = 1; rd_data = rnd_line(); #1;
    checks++;
    if ({rd_req, up} !== 7'h00) begin failures++; $display("FAIL rst_mid_late_ready got=%b exp=0", {rd_req, up}); end
    cyc(1);
    rd_ready = 0;
    checks++;
    if ({rd_req, wr_req} !== 2'b00) begin failures++; $display("FAIL rst_mid_after got=%b exp=00", {rd_req, wr_req}); end
  endtask

  task automatic test_spurious();
    d_rd_req = 1; d_rd_addr = 32'h8000_7000;
    cyc(1);
    wr_ready = 1; wr_error = 1; #1;
    checks++;
    if (up !== 6'b0) begin failures++; $display("FAIL spur_wr_in_rd got=%b exp=0", up); end
    cyc(1);
    wr_ready = 0; wr_error = 0;
    checks++;
    if ({rd_req, wr_req} !== 2'b10) begin failures++; $display("FAIL spur_rd_hold got=%b exp=10", {rd_req, wr_req}); end
    rd_ready = 1; #1;
    cyc(1);
    d_rd_req = 0; rd_ready = 1; rd_error = 1; #1;
    checks++;
    if (up !== 6'b0) begin failures++; $display("FAIL spur_rd_in_idle got=%b exp=0", up); end
    cyc(1);
    rd_ready = 0; rd_error = 0;
    checks++;
    if ({rd_req, wr_req} !== 2'b00) begin failures++; $display("FAIL spur_idle_hold got=%b exp=00", {rd_req, wr_req}); end
  endtask

  // Model: pending flags per requester, writeback wins, reads alternate
  // starting with D after reset; pointer moves on read grants only.
  task automatic test_random();
    bit pend_w, pend_i, pend_d, fav_d, err;
    int own;  // 0 = D write, 1 = I read, 2 = D read
    int lat;
    logic [AL-1:0] exp_addr;
    logic [LL-1:0] exp_wd, dat;
    logic [5:0] exp_up;
    do_reset();
    pend_w = 0; pend_i = 0; pend_d = 0; fav_d = 1;
    for (int it = 0; it < 150; it++) begin
      checks++;
      if ({rd_req, wr_req} !== 2'b00) begin failures++; $display("FAIL rnd_idle%0d got=%b exp=00", it, {rd_req, wr_req}); end
      if (!pend_w && $urandom_range(0, 2) == 0) begin
        pend_w = 1; d_wr_req = 1; d_wr_addr = $urandom; d_wr_data = rnd_line();
      end
      if (!pend_i && $urandom_range(0, 1) == 0) begin pend_i = 1; i_rd_req = 1; i_addr = $urandom; end
      if (!pend_d && $urandom_range(0, 1) == 0) begin pend_d = 1; d_rd_req = 1; d_rd_addr = $urandom; end
      if (!pend_w && !pend_i && !pend_d) begin pend_i = 1; i_rd_req = 1; i_addr = $urandom; end
      if (pend_w) own = 0;
      else if (pend_i && pend_d) own = fav_d ? 2 : 1;
      else own = pend_i ? 1 : 2;
      exp_addr = (own == 0) ? d_wr_addr : (own == 1) ? i_addr : d_rd_addr;
      exp_wd = d_wr_data;
      if (own != 0) fav_d = (own == 1);
      cyc(1);
      checks++;
      if ({rd_req, wr_req, addr} !== {own != 0, own == 0, exp_addr}) begin
        failures++; $display("FAIL rnd_grant%0d rd=%0b wr=%0b addr=%h exp_own=%0d exp_addr=%h", it, rd_req, wr_req, addr, own, exp_addr);
      end
      if (own == 0) begin
        checks++;
        if (wr_data !== exp_wd) begin failures++; $display("FAIL rnd_wdata%0d got=%h exp=%h", it, wr_data, exp_wd); end
      end
      lat = $urandom_range(0, 3);
      for (int k = 0; k < lat; k++) begin
        if (own == 0) rd_ready = $urandom_range(0, 1);
        else wr_ready = $urandom_range(0, 1);
        if ($urandom_range(0, 3) == 0) begin
          if (own == 0) begin d_wr_req = 0; pend_w = 0; end
          else if (own == 1) begin i_rd_req = 0; pend_i = 0; end
          else begin d_rd_req = 0; pend_d = 0; end
        end
        #1;
        checks++;
        if (up !== 6'b0) begin failures++; $display("FAIL rnd_wait%0d got=%b exp=0", it, up); end
        cyc(1);
        rd_ready = 0; wr_ready = 0;
      end
      err = 1'($urandom_range(0, 1)); dat = rnd_line();
      if (own == 0) begin wr_ready = 1; wr_error = err; end
      else begin rd_ready = 1; rd_error = err; rd_data = dat; end
      #1;
      exp_up = (own == 1) ? {1'b1, err, 4'b0} : (own == 2) ? {2'b0, 1'b1, err, 2'b0} : {4'b0, 1'b1, err};
      checks++;
      if (up !== exp_up) begin failures++; $display("FAIL rnd_ready%0d got=%b exp=%b", it, up, exp_up); end
      checks++;
      if (i_rd_data !== ((own == 1) ? dat : '0) || d_rd_data !== ((own == 2) ? dat : '0)) begin
        failures++; $display("FAIL rnd_rdata%0d own=%0d", it, own);
      end
      cyc(1);
      rd_ready = 0; wr_ready = 0; rd_error = 0; wr_error = 0; rd_data = '0;
      if (own == 0) begin d_wr_req = 0; pend_w = 0; end
      else if (own == 1) begin i_rd_req = 0; pend_i = 0; end
      else begin d_rd_req = 0; pend_d = 0; end
    end
    idle_inputs();
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_single_refill();
    test_contention();
    test_wb_priority();
    test_error();
    test_reset_mid_rd();
    test_spurious();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_040066_axi_arbiter.md
YSYX_040066_AXI_ARBITER -- requirements
Module: ysyx_040066_axi_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_LEN, default 512, meaning the cache line width in bits on every data bus.
REQ-002 The block SHALL have parameter ADDR_LEN, default 32, meaning the physical address width.
REQ-003 The block SHALL have port clk, in, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, in, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have I-cache ports i_rd_req in 1, i_addr in ADDR_LEN, i_rd_ready out 1, i_rd_error out 1, i_rd_data out LINE_LEN; the I-cache issues line refills only.
REQ-006 The block SHALL have D-cache read ports d_rd_req in 1, d_rd_addr in ADDR_LEN, d_rd_ready out 1, d_rd_error out 1, d_rd_data out LINE_LEN.
REQ-007 The block SHALL have D-cache write ports d_wr_req in 1, d_wr_addr in ADDR_LEN, d_wr_data in LINE_LEN, d_wr_ready out 1, d_wr_error out 1.
REQ-008 The block SHALL have downstream AXI-bridge ports addr out ADDR_LEN, rd_req out 1, rd_ready in 1, rd_error in 1, rd_data in LINE_LEN, wr_req out 1, wr_data out LINE_LEN, wr_ready in 1, wr_error in 1.

Function
REQ-009 The block SHALL use a level request / one-cycle-pulse ready protocol: a requester holds req and its operands stable until its ready pulse, then deasserts req no later than the following cycle.
REQ-010 The block SHALL implement states IDLE, RD, WR; at most one downstream transaction SHALL be outstanding.
REQ-011 In IDLE with any request pending, the block SHALL select a winner, register grant owner, addr and (for writes) wr_data, and enter RD or WR on the next edge.
REQ-012 Arbitration SHALL be: d_wr_req first (writeback precedes refill); otherwise round-robin between i_rd_req and d_rd_req, with a 1-bit last-winner pointer toggled only on granted reads; pointer reset value favours the D-cache.
REQ-013 rd_req SHALL be 1 exactly while in RD; wr_req SHALL be 1 exactly while in WR; addr and wr_data SHALL come from the registered copies, never directly from requester inputs.
REQ-014 In RD, a rd_ready pulse SHALL be routed combinationally, in the same cycle, to i_rd_ready or d_rd_ready of the owner, with rd_error and rd_data forwarded on the matching outputs; the state SHALL return to IDLE on the next edge.
REQ-015 In WR, a wr_ready pulse SHALL be routed the same cycle to d_wr_ready/d_wr_error; state SHALL return to IDLE on the next edge.
REQ-016 Ready/error outputs of non-owners SHALL be 0; data outputs SHALL be 0 when not owner-ready.
REQ-017 Latency SHALL be: request seen in IDLE at cycle N gives downstream req at N+1; ready at cycle M gives IDLE at M+1 and the next downstream req at the earliest at M+2.
REQ-018 A requester dropping req mid-transaction SHALL NOT abort it; the transaction completes and the ready pulse is still emitted.
REQ-019 rd_ready in IDLE/WR and wr_ready in IDLE/RD SHALL be ignored and SHALL NOT be forwarded.
REQ-020 An error response SHALL end the transaction like a normal one; there SHALL be no retry.

Reset
REQ-021 While rst=0, state SHALL be IDLE; rd_req, wr_req, addr, wr_data, the grant owner, all ready/error/data outputs SHALL be 0; round-robin pointer SHALL select the D-cache next.
REQ-022 Reset asserted mid-transaction SHALL drop rd_req/wr_req immediately (asynchronous); no ready SHALL be emitted for the aborted transaction.

Structure
REQ-023 State encoding (IDLE/RD/WR) and owner encoding (OWN_I, OWN_D) SHALL be defined in the shared cache package, along with the LINE_LEN and ADDR_LEN defaults used by the cache and AXI bridge.
REQ-024 The arbitration decision (REQ-012) SHALL be a sub-module ysyx_040066_rr_pick2; the rest SHALL be a single FSM with registered outputs.

Verification
REQ-025 Single refill: i_rd_req=1, i_addr=0x8000_0040; rd_ready after 5 cycles with rd_data pattern -> rd_req high 5 cycles, addr=0x8000_0040, i_rd_ready one pulse with the same data, d_rd_ready 0.
REQ-026 Contention: i_rd_req and d_rd_req both asserted from reset -> D served first, then I; with both held continuously grants SHALL alternate D,I,D,I.
REQ-027 Writeback priority: d_wr_req (0x8000_1000, data 0xA5-pattern) and i_rd_req together -> WR first with wr_data matching, d_wr_ready pulse, then RD for I.
REQ-028 Error: rd_error=1 with rd_ready -> owner sees ready=1, error=1 same cycle; FSM in IDLE next cycle; next request accepted.
REQ-029 Reset mid-RD: rst=0 two cycles into RD -> rd_req 0 asynchronously; a late rd_ready after release is not forwarded.
REQ-030 Spurious: wr_ready pulse during RD and rd_ready in IDLE -> no upstream ready, state unchanged.
